// File: rtl/me_pkg.sv
// Shared constants and types for the full-search block-matching motion
// estimator sequencer.
//   N_PE     : number of PEs, also the reference block edge
//   BLK_PIX  : pixels per reference block (one candidate's accumulation length)
//   LAST_T   : final value of the cycle counter (last PE's last result)
//   SW_EDGE  : search window edge, the row pitch of the search memories
package me_pkg;

    localparam int unsigned N_PE     = 16;
    localparam int unsigned BLK_PIX  = 256;
    localparam int unsigned LAST_T   = 4110;
    localparam int unsigned SW_EDGE  = 32;
    localparam int unsigned CNT_W    = 13;
    localparam int unsigned ADDR_R_W = 8;
    localparam int unsigned ADDR_S_W = 10;

    // Last counter value of the RUN phase: 16 candidate rows of 256 pixels.
    localparam int unsigned RUN_LAST = N_PE * BLK_PIX - 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } me_state_t;

endpackage

// File: rtl/me_pe_decode.sv
// Per-PE strobe decode. PE IDX runs IDX cycles behind PE 0, so its local
// time is u = t - IDX.
//   t        : sequencer cycle counter
//   active   : high during RUN and DRAIN
//   newdist  : accumulator clear/restart for this PE
//   peready  : result-valid strobe for this PE
//   s1s2mux  : 1 selects search memory 1, 0 selects memory 2 (RUN only)
module me_pe_decode
    import me_pkg::*;
#(
    parameter int unsigned IDX = 0
) (
    input  logic [CNT_W-1:0] t,
    input  logic             active,
    output logic             newdist,
    output logic             peready,
    output logic             s1s2mux
);

    logic [CNT_W-1:0] u;
    logic [4:0]       col_diff;
    logic             valid;

    always_comb begin
        // When t < IDX the subtraction wraps far above RUN_LAST, so the
        // range check alone also rejects the not-yet-started case.
        u        = t - CNT_W'(IDX);
        valid    = active && (u <= CNT_W'(RUN_LAST));
        newdist  = valid && (u[7:0] == 8'h00);
        peready  = valid && (u[7:0] == 8'hFF);
        // Column c >= IDX, evaluated as the sign of a 5-bit difference.
        col_diff = {1'b0, t[3:0]} - 5'(IDX);
        s1s2mux  = active && (t <= CNT_W'(RUN_LAST)) && !col_diff[4];
    end

endmodule

// File: rtl/me_control.sv
// Sequencer for the full-search block-matching motion estimator: one 16x16
// reference block against a 32x32 search window (16x16 candidates).
//   clock      : system clock, rising edge
//   resetn     : asynchronous active-low reset
//   start      : begin a search, sampled in IDLE only
//   abort      : synchronous cancel back to IDLE
//   AddressR   : reference block address {row,col}
//   AddressS1  : search memory 1 address
//   AddressS2  : search memory 2 address
//   S1S2mux    : per-PE source select, 1 = S1
//   NewDist    : per-PE accumulator clear/restart strobe
//   PEready    : per-PE result-valid strobe (one-hot or zero)
//   vectorX/Y  : candidate vector of the result being presented
//   CompStart  : comparator enable, 0 clears BestDist
//   busy       : high in CLEAR, RUN and DRAIN
//   done       : one-cycle pulse at end of search
module me_control #(
    parameter int unsigned N_PE  = 16,
    parameter int unsigned CNT_W = 13
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    output logic [7:0]          AddressR,
    output logic [9:0]          AddressS1,
    output logic [9:0]          AddressS2,
    output logic [N_PE-1:0]     S1S2mux,
    output logic [N_PE-1:0]     NewDist,
    output logic [N_PE-1:0]     PEready,
    output logic [3:0]          vectorX,
    output logic [3:0]          vectorY,
    output logic                CompStart,
    output logic                busy,
    output logic                done
);

    import me_pkg::*;

    me_state_t        state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             comp_q, comp_d;
    logic [3:0]       tag_x_q, tag_y_q;

    logic             run, active, abort_taken;
    logic [4:0]       kr_sum;
    logic             hit;
    logic [3:0]       hit_x, hit_y;
    logic [CNT_W-1:0] u_hit;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            t_q     <= '0;
            comp_q  <= 1'b0;
            tag_x_q <= '0;
            tag_y_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            comp_q  <= comp_d;
            if (hit) begin
                tag_x_q <= hit_x;
                tag_y_q <= hit_y;
            end
        end
    end

    // Next-state and counter
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        abort_taken = abort && (state_q != StIdle);
        if (abort_taken) begin
            state_d = StIdle;
            t_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    t_d = '0;
                    if (start && !abort) state_d = StClear;
                end
                StClear: begin
                    state_d = StRun;
                    t_d     = '0;
                end
                StRun: begin
                    t_d = t_q + 1'b1;
                    if (t_q == CNT_W'(RUN_LAST)) state_d = StDrain;
                end
                StDrain: begin
                    // Counter parks at LAST_T instead of wrapping.
                    if (t_q == CNT_W'(LAST_T)) state_d = StDone;
                    else                       t_d = t_q + 1'b1;
                end
                StDone: begin
                    state_d = StIdle;
                    t_d     = '0;
                end
                default: begin
                    state_d = StIdle;
                    t_d     = '0;
                end
            endcase
        end
    end

    // Comparator enable: cleared on entering CLEAR or on abort, set while a
    // search is live, and held in IDLE so the best match stays readable.
    always_comb begin
        comp_d = comp_q;
        unique case (state_d)
            StClear:                comp_d = 1'b0;
            StRun, StDrain, StDone: comp_d = 1'b1;
            default:                comp_d = abort_taken ? 1'b0 : comp_q;
        endcase
    end

    // Outputs
    always_comb begin
        run       = (state_q == StRun);
        active    = run || (state_q == StDrain);
        busy      = (state_q == StClear) || active;
        done      = (state_q == StDone);
        CompStart = comp_q;

        // k = t[11:8] is the candidate row, r = t[7:4] the block row.
        kr_sum    = {1'b0, t_q[11:8]} + {1'b0, t_q[7:4]};
        AddressR  = run ? t_q[7:0] : 8'h00;
        AddressS1 = run ? (10'(kr_sum) * 10'(SW_EDGE) + 10'(t_q[3:0])) : 10'h000;
        AddressS2 = run ? (AddressS1 + 10'(N_PE)) : 10'h000;
    end

    for (genvar i = 0; i < N_PE; i++) begin : g_pe
        me_pe_decode #(
            .IDX (i)
        ) u_pe_decode (
            .t       (t_q),
            .active  (active),
            .newdist (NewDist[i]),
            .peready (PEready[i]),
            .s1s2mux (S1S2mux[i])
        );
    end

    // Vector tag: the ready PE gives X, its local time gives Y.
    always_comb begin
        hit   = 1'b0;
        hit_x = '0;
        hit_y = '0;
        u_hit = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (PEready[i]) begin
                hit   = 1'b1;
                hit_x = 4'(i);
                u_hit = t_q - CNT_W'(i);
                hit_y = u_hit[11:8];
            end
        end
        vectorX = hit ? hit_x : tag_x_q;
        vectorY = hit ? hit_y : tag_y_q;
    end

endmodule

// File: tb/tb_me_control.sv
module tb_me_control;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1;
    logic [9:0]  AddressS2;
    logic [15:0] S1S2mux;
    logic [15:0] NewDist;
    logic [15:0] PEready;
    logic [3:0]  vectorX;
    logic [3:0]  vectorY;
    logic        CompStart;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;   // cycles since start was asserted
    int pulses   = 0;   // PEready bits seen since the current run began
    bit multi_hot = 0;

    me_control #(
        .N_PE  (16),
        .CNT_W (13)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .S1S2mux   (S1S2mux),
        .NewDist   (NewDist),
        .PEready   (PEready),
        .vectorX   (vectorX),
        .vectorY   (vectorY),
        .CompStart (CompStart),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        pulses += $countones(PEready);
        if ($countones(PEready) > 1) multi_hot = 1'b1;
    endtask

    // Step until the bench's own counter model reaches t = tt (t = cyc - 2).
    task automatic run_to(input int tt);
        while (cyc - 2 < tt) step();
    endtask

    task automatic begin_run();
        start  = 1'b1;
        cyc    = 0;
        pulses = 0;
        multi_hot = 1'b0;
        step();
        start = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b1;
        abort  = 1'b0;

        // Reset held while start is high: nothing may move.
        step(); step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_comp", CompStart, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", {vectorX, vectorY}, 0);
        chk("rst_strobes", {PEready, NewDist, S1S2mux}, 0);
        chk("rst_addr", {AddressR, AddressS1, AddressS2}, 0);
        start  = 1'b0;
        resetn = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // ---- Run 1: full search with a stray start mid-run ----
        begin_run();
        chk("clear_comp", CompStart, 0);
        chk("clear_busy", busy, 1);
        chk("clear_newdist", NewDist, 0);
        step();
        chk("t0_newdist", NewDist, 16'h0001);
        chk("t0_comp", CompStart, 1);
        chk("t0_addrs2", AddressS2, 16);
        run_to(15);
        chk("t15_newdist", NewDist, 16'h8000);
        run_to(255);
        chk("t255_ready", PEready, 16'h0001);
        chk("t255_vec", {vectorX, vectorY}, 8'h00);
        run_to(256);
        chk("t256_ready", PEready, 16'h0002);
        chk("t256_newdist", NewDist, 16'h0001);
        chk("t256_vec", {vectorX, vectorY}, 8'h10);
        run_to(271);
        chk("t271_ready", PEready, 0);
        chk("t271_vec_hold", {vectorX, vectorY}, 8'hF0);
        run_to(291);
        chk("t123_addrr", AddressR, 8'h23);
        chk("t123_addrs1", AddressS1, 99);
        chk("t123_addrs2", AddressS2, 115);
        chk("t123_mux", S1S2mux, 16'h000F);
        run_to(511);
        chk("t511_ready", PEready, 16'h0001);
        chk("t511_vec", {vectorX, vectorY}, 8'h01);
        run_to(1000);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1001_busy", busy, 1);
        chk("t1001_addrr", AddressR, 8'hE9);
        run_to(4100);
        chk("drain_addr", {AddressR, AddressS1, AddressS2}, 0);
        chk("drain_mux", S1S2mux, 0);
        chk("drain_ready", PEready, 16'h0020);
        chk("drain_vec", {vectorX, vectorY}, 8'h5F);
        run_to(4110);
        chk("last_ready", PEready, 16'h8000);
        chk("last_vec", {vectorX, vectorY}, 8'hFF);
        chk("last_done", done, 0);
        step();
        chk("done_cycle", cyc, 4113);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_strobes", {PEready, NewDist}, 0);
        step();
        chk("idle_done", done, 0);
        chk("idle_comp_held", CompStart, 1);
        chk("idle_vec_held", {vectorX, vectorY}, 8'hFF);
        chk("run1_pulses", pulses, 256);
        chk("run1_onehot", multi_hot, 0);

        // ---- Run 2: abort mid-run, then start+abort together in IDLE ----
        begin_run();
        chk("run2_clear_comp", CompStart, 0);
        run_to(2000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_comp", CompStart, 0);
        chk("abort_ready", PEready, 0);
        chk("abort_done", done, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        step();
        chk("start_abort_idle2", busy, 0);

        // ---- Run 3: asynchronous reset in DRAIN ----
        begin_run();
        run_to(4100);
        chk("run3_drain_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_comp", CompStart, 0);
        chk("async_vec", {vectorX, vectorY}, 0);
        chk("async_strobes", {PEready, NewDist, S1S2mux}, 0);
        chk("async_addr", {AddressR, AddressS1, AddressS2}, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        // ---- Run 4: normal full run after reset ----
        begin_run();
        chk("run4_clear_busy", busy, 1);
        run_to(4110);
        chk("run4_last_ready", PEready, 16'h8000);
        chk("run4_last_vec", {vectorX, vectorY}, 8'hFF);
        step();
        chk("run4_done_cycle", cyc, 4113);
        chk("run4_done", done, 1);
        chk("run4_pulses", pulses, 256);
        chk("run4_onehot", multi_hot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
